// File: rtl/sid_reg_if_if.sv
// Host write bus for the SID register file: raw strobe/fields in, accepted-write event out.
interface sid_reg_if_if;
  logic       wr_strobe_i;
  logic [2:0] addr_i;
  logic [1:0] voice_i;
  logic [7:0] data_i;
  logic       wr_pulse_o;
  logic [1:0] wr_voice_o;
  logic [2:0] wr_addr_o;
  logic [7:0] wr_data_o;

  modport master (
    output wr_strobe_i, addr_i, voice_i, data_i,
    input  wr_pulse_o, wr_voice_o, wr_addr_o, wr_data_o
  );

  modport slave (
    input  wr_strobe_i, addr_i, voice_i, data_i,
    output wr_pulse_o, wr_voice_o, wr_addr_o, wr_data_o
  );
endinterface

// File: rtl/sid_reg_if.sv
// SID register file fed by an asynchronous host strobe: synchronise, edge-detect,
// write the addressed byte and flag gate-bit transitions on voice control registers.
module sid_reg_if #(
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic           clk,
  input  logic           rst,
  sid_reg_if_if.slave    bus,
  output logic [255:0]   regs_o,
  output logic [2:0]     gate_on_o,
  output logic [2:0]     gate_off_o
);

  logic [SYNC_STAGES-1:0] sync_q;
  logic [SYNC_STAGES-1:0] fill_q;
  logic                   strobe_s;
  logic                   prev_q;
  logic                   armed_q;
  logic                   rise_q;
  logic                   pend_q;
  logic                   pulse_q;
  logic [1:0]             voice_q;
  logic [2:0]             addr_q;
  logic [7:0]             data_q;
  logic [255:0]           regs_q;
  logic [2:0]             gate_on_q;
  logic [2:0]             gate_off_q;

  logic                   writable;
  logic                   ctrl_write;
  logic                   old_gate;
  logic [2:0]             voice_mask;

  assign strobe_s = sync_q[SYNC_STAGES-1];

  always_comb begin
    writable   = 1'b0;
    ctrl_write = 1'b0;
    old_gate   = 1'b0;
    voice_mask = '0;
    if (voice_q == 2'd3) begin
      writable = (addr_q <= 3'd3);
    end else begin
      writable   = (addr_q != 3'd7);
      ctrl_write = pend_q && (addr_q == 3'd6);
      voice_mask = 3'b001 << voice_q;
    end
    old_gate = regs_q[{voice_q, addr_q, 3'b000}];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sync_q     <= '0;
      fill_q     <= '0;
      prev_q     <= 1'b0;
      armed_q    <= 1'b0;
      rise_q     <= 1'b0;
      pend_q     <= 1'b0;
      pulse_q    <= 1'b0;
      voice_q    <= '0;
      addr_q     <= '0;
      data_q     <= '0;
      regs_q     <= '0;
      gate_on_q  <= '0;
      gate_off_q <= '0;
    end else begin
      sync_q  <= {sync_q[SYNC_STAGES-2:0], bus.wr_strobe_i};
      // fill_q marks when the chain holds only post-reset samples, so the
      // cleared flops are never mistaken for a genuine low strobe.
      fill_q  <= {fill_q[SYNC_STAGES-2:0], 1'b1};
      prev_q  <= strobe_s;
      armed_q <= armed_q | (fill_q[SYNC_STAGES-1] & ~strobe_s);
      rise_q  <= strobe_s & ~prev_q & armed_q & fill_q[SYNC_STAGES-1];
      pend_q  <= rise_q;
      pulse_q <= pend_q;
      if (rise_q) begin
        voice_q <= bus.voice_i;
        addr_q  <= bus.addr_i;
        data_q  <= bus.data_i;
      end
      if (pend_q && writable) begin
        regs_q[{voice_q, addr_q, 3'b000} +: 8] <= data_q;
      end
      gate_on_q  <= '0;
      gate_off_q <= '0;
      if (ctrl_write && (data_q[0] != old_gate)) begin
        if (data_q[0]) gate_on_q  <= voice_mask;
        else           gate_off_q <= voice_mask;
      end
    end
  end

  assign regs_o         = regs_q;
  assign gate_on_o      = gate_on_q;
  assign gate_off_o     = gate_off_q;
  assign bus.wr_pulse_o = pulse_q;
  assign bus.wr_voice_o = voice_q;
  assign bus.wr_addr_o  = addr_q;
  assign bus.wr_data_o  = data_q;

endmodule

// File: tb/tb_sid_reg_if.sv
// Scoreboard bench for sid_reg_if: each strobe pushes the expected write event.
module tb_sid_reg_if;
  localparam int unsigned N = 2;

  logic         clk = 1'b0;
  logic         rst;
  logic [255:0] regs;
  logic [2:0]   gon;
  logic [2:0]   goff;

  always #5 clk = ~clk;

  sid_reg_if_if bus ();

  sid_reg_if #(.SYNC_STAGES(N)) dut (
    .clk        (clk),
    .rst        (rst),
    .bus        (bus),
    .regs_o     (regs),
    .gate_on_o  (gon),
    .gate_off_o (goff)
  );

  typedef struct {
    logic [1:0]   v;
    logic [2:0]   a;
    logic [7:0]   d;
    logic [2:0]   on;
    logic [2:0]   off;
    int unsigned  cyc;
    logic [255:0] regs;
  } exp_t;

  exp_t         sb[$];
  logic [255:0] model;
  int           checks = 0;
  int           errors = 0;
  int unsigned  cyc    = 0;
  int unsigned  pulses = 0;

  always @(posedge clk) cyc = cyc + 1;

  always @(posedge clk) begin
    #1;
    if (!rst) begin
      if (bus.wr_pulse_o) begin
        pulses = pulses + 1;
        checks++;
        if (sb.size() == 0) begin
          errors++;
          $display("FAIL unexpected_pulse: got pulse at cycle %0d, required none", cyc);
        end else begin
          exp_t e;
          e = sb.pop_front();
          if ({bus.wr_voice_o, bus.wr_addr_o, bus.wr_data_o} !== {e.v, e.a, e.d}) begin
            errors++;
            $display("FAIL fields: got v%0d a%0d d%h, required v%0d a%0d d%h",
                     bus.wr_voice_o, bus.wr_addr_o, bus.wr_data_o, e.v, e.a, e.d);
          end
          checks++;
          if (regs !== e.regs) begin
            errors++;
            $display("FAIL regs: got %h, required %h", regs, e.regs);
          end
          checks++;
          if ({gon, goff} !== {e.on, e.off}) begin
            errors++;
            $display("FAIL gate: got on=%b off=%b, required on=%b off=%b", gon, goff, e.on, e.off);
          end
          checks++;
          if (cyc !== e.cyc) begin
            errors++;
            $display("FAIL latency: pulse at cycle %0d, required %0d", cyc, e.cyc);
          end
        end
      end else begin
        checks++;
        if ((gon | goff) !== 3'b000) begin
          errors++;
          $display("FAIL stray_gate: got on=%b off=%b without pulse, required 000", gon, goff);
        end
      end
    end
  end

  task automatic wait_pulses(input int unsigned target);
    for (int i = 0; i < 80 && pulses < target; i++) @(negedge clk);
    checks++;
    if (pulses != target) begin
      errors++;
      $display("FAIL pulse_timeout: got %0d pulses, required %0d", pulses, target);
    end
  endtask

  task automatic drive_write(input logic [1:0] v, input logic [2:0] a,
                             input logic [7:0] d, input int hi);
    exp_t        e;
    int unsigned p0;
    logic        old;
    p0    = pulses;
    e.v   = v;
    e.a   = a;
    e.d   = d;
    e.on  = '0;
    e.off = '0;
    if (v != 2'd3 && a == 3'd6) begin
      old = model[{v, a, 3'b000}];
      if (d[0] && !old) e.on[v]  = 1'b1;
      if (!d[0] && old) e.off[v] = 1'b1;
    end
    if ((v == 2'd3) ? (a < 3'd4) : (a < 3'd7)) model[{v, a, 3'b000} +: 8] = d;
    e.regs = model;
    @(negedge clk);
    bus.voice_i     = v;
    bus.addr_i      = a;
    bus.data_i      = d;
    bus.wr_strobe_i = 1'b1;
    e.cyc = cyc + N + 3;
    sb.push_back(e);
    repeat (hi) @(negedge clk);
    bus.wr_strobe_i = 1'b0;
    wait_pulses(p0 + 1);
    repeat (3) @(negedge clk);
  endtask

  task automatic test_reset;
    rst = 1'b1;
    bus.wr_strobe_i = 1'b0;
    bus.addr_i = '0;
    bus.voice_i = '0;
    bus.data_i = '0;
    repeat (3) @(negedge clk);
    checks++;
    if (regs !== '0) begin errors++; $display("FAIL reset_regs: got %h, required 0", regs); end
    checks++;
    if (bus.wr_pulse_o !== 1'b0) begin errors++; $display("FAIL reset_pulse: got %b, required 0", bus.wr_pulse_o); end
    checks++;
    if ({gon, goff} !== 6'b0) begin errors++; $display("FAIL reset_gates: got %b, required 0", {gon, goff}); end
    checks++;
    if ({bus.wr_voice_o, bus.wr_addr_o, bus.wr_data_o} !== 13'b0) begin
      errors++;
      $display("FAIL reset_fields: got %h, required 0", {bus.wr_voice_o, bus.wr_addr_o, bus.wr_data_o});
    end
    rst = 1'b0;
    model = '0;
    repeat (5) @(negedge clk);
  endtask

  task automatic test_single_write;
    drive_write(2'd0, 3'd0, 8'hD6, 2);
    checks++;
    if (regs !== {248'b0, 8'hD6}) begin
      errors++;
      $display("FAIL single_write: got %h, required only byte0=d6", regs);
    end
  endtask

  task automatic test_voice_sequence;
    int unsigned p0;
    logic [7:0]  vals [6] = '{8'hD6, 8'h1C, 8'h00, 8'h08, 8'h00, 8'hF0};
    p0 = pulses;
    for (int i = 0; i < 6; i++) drive_write(2'd0, 3'(i), vals[i], 2);
    drive_write(2'd3, 3'd3, 8'h0F, 3);
    checks++;
    if (regs[47:0] !== 48'hF0_00_08_00_1C_D6) begin
      errors++;
      $display("FAIL voice_seq_bytes: got %h, required f000080 01cd6", regs[47:0]);
    end
    checks++;
    if (regs[27*8 +: 8] !== 8'h0F) begin
      errors++;
      $display("FAIL mode_vol: got %h, required 0f", regs[27*8 +: 8]);
    end
    checks++;
    if (pulses - p0 != 7) begin
      errors++;
      $display("FAIL seq_pulse_count: got %0d, required 7", pulses - p0);
    end
  endtask

  task automatic test_gate;
    drive_write(2'd0, 3'd6, 8'h11, 2);
    drive_write(2'd0, 3'd6, 8'h11, 2);
    drive_write(2'd0, 3'd6, 8'h10, 2);
    drive_write(2'd2, 3'd6, 8'h41, 2);
    drive_write(2'd2, 3'd6, 8'h40, 2);
    checks++;
    if (regs[6*8 +: 8] !== 8'h10 || regs[22*8 +: 8] !== 8'h40) begin
      errors++;
      $display("FAIL gate_ctrl_bytes: got %h/%h, required 10/40", regs[6*8 +: 8], regs[22*8 +: 8]);
    end
  endtask

  task automatic test_long_strobe;
    int unsigned p0;
    p0 = pulses;
    drive_write(2'd1, 3'd2, 8'h5A, 50);
    checks++;
    if (pulses - p0 != 1) begin
      errors++;
      $display("FAIL long_strobe: got %0d pulses, required 1", pulses - p0);
    end
    drive_write(2'd3, 3'd5, 8'hAA, 2);
    drive_write(2'd1, 3'd7, 8'h33, 2);
    checks++;
    if (regs[29*8 +: 8] !== 8'h00 || regs[15*8 +: 8] !== 8'h00) begin
      errors++;
      $display("FAIL unwritable: got %h/%h, required 00/00", regs[29*8 +: 8], regs[15*8 +: 8]);
    end
  endtask

  task automatic test_reset_abort;
    int unsigned p0;
    p0 = pulses;
    @(negedge clk);
    bus.voice_i = 2'd3;
    bus.addr_i = 3'd0;
    bus.data_i = 8'h77;
    bus.wr_strobe_i = 1'b1;
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    model = '0;
    checks++;
    if (regs !== '0) begin errors++; $display("FAIL abort_regs: got %h, required 0", regs); end
    repeat (12) @(negedge clk);
    checks++;
    if (pulses != p0) begin
      errors++;
      $display("FAIL abort_no_write: got %0d pulses, required %0d", pulses, p0);
    end
    bus.wr_strobe_i = 1'b0;
    repeat (3) @(negedge clk);
    drive_write(2'd3, 3'd0, 8'h77, 2);
    checks++;
    if (pulses != p0 + 1 || regs[24*8 +: 8] !== 8'h77) begin
      errors++;
      $display("FAIL abort_rewrite: got %0d pulses byte24=%h, required %0d/77", pulses - p0, regs[24*8 +: 8], 1);
    end
  endtask

  initial begin
    test_reset;
    test_single_write;
    test_voice_sequence;
    test_gate;
    test_long_strobe;
    test_reset_abort;
    repeat (5) @(negedge clk);
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL leftover: got %0d pending writes, required 0", sb.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end
endmodule
